// File: rtl/job_seq_pkg.sv
// Shared types and helpers for the job sequencer and its timer.
package job_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // Width of the saturating stray-done counter (optional feature).
   localparam int STRAY_W = 8;

   // Bits needed to count the cycles of one WAIT window.
   function automatic int timer_width(input int timeout_cycles);
      return $clog2(timeout_cycles);
   endfunction

endpackage

// File: rtl/job_seq_timer.sv
// Per-job watchdog for start/done initiators. Clear it on the issue cycle and
// enable it while waiting; expired is high on the last allowed wait cycle, so a
// timed-out job is re-issued exactly TIMEOUT_CYCLES cycles after its start.
module job_seq_timer
   import job_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int             W    = timer_width(TIMEOUT_CYCLES);
   localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 2);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Count wait cycles; park on the last value so expired stays asserted.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/job_sequencer.sv
// Batch initiator for the start/done handshake: one start pulse per job, waits
// for done, supervises each job with a timeout and bounded retry.
// Build option JOB_SEQUENCER_STRAY_CNT_EN adds stray_count, a saturating count
// of done pulses seen outside WAIT.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for go; error and jobs_done hold last batch result
// ISSUE | start pulse for the current job, timer cleared
// WAIT  | waiting for done; timer running, retry/abort handled here
// DONE  | complete pulse, back to IDLE
module job_sequencer
   import job_seq_pkg::*;
#(
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [CNT_W-1:0] job_count,
   input  logic             abort,
   output logic             start,
   input  logic             done,
   output logic             busy,
   output logic             complete,
   output logic             error,
   output logic [CNT_W-1:0] jobs_done
`ifdef JOB_SEQUENCER_STRAY_CNT_EN
   ,
   output logic [STRAY_W-1:0] stray_count
`endif
);

   localparam int                 RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [CNT_W-1:0]   JOBS_SAT  = '1;

   seq_state_t         state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   jobs_q, jobs_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               error_q, error_d;
   logic [CNT_W-1:0]   jobs_inc;
   logic               timer_expired;

   job_seq_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q == ISSUE),
      .enable  (state_q == WAIT),
      .expired (timer_expired)
   );

   assign jobs_inc = jobs_q + 1'b1;

   // Next-state and batch bookkeeping; abort outranks done and timeout.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      jobs_d  = jobs_q;
      retry_d = retry_q;
      error_d = error_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               count_d = job_count;
               jobs_d  = '0;
               error_d = 1'b0;
               retry_d = '0;
               state_d = (job_count == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            state_d = abort ? IDLE : WAIT;
         end
         WAIT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (done) begin
               retry_d = '0;
               if (jobs_q != JOBS_SAT) begin
                  jobs_d = jobs_inc;
               end
               state_d = (jobs_inc == count_q) ? DONE : ISSUE;
            end else if (timer_expired) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 1'b1;
                  state_d = ISSUE;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and batch registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         jobs_q  <= '0;
         retry_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         jobs_q  <= jobs_d;
         retry_q <= retry_d;
         error_q <= error_d;
      end
   end

   assign start     = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign complete  = (state_q == DONE);
   assign error     = error_q;
   assign jobs_done = jobs_q;

`ifdef JOB_SEQUENCER_STRAY_CNT_EN
   logic [STRAY_W-1:0] stray_q, stray_d;

   // Count done pulses that arrive while no job is being waited on.
   always_comb begin
      stray_d = stray_q;
      if ((state_q == IDLE) && go) begin
         stray_d = '0;
      end else if (done && (state_q != WAIT) && (stray_q != '1)) begin
         stray_d = stray_q + 1'b1;
      end
   end

   // Stray counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stray_q <= '0;
      end else begin
         stray_q <= stray_d;
      end
   end

   assign stray_count = stray_q;
`endif

endmodule

// File: tb/tb_job_sequencer.sv
// Bench for job_sequencer: a job-level model expands each directed scenario
// (job count, worker response per issue, abort/extra pulses) into expected
// per-cycle outputs, and one compare process checks them every cycle.
module tb_job_sequencer;

   localparam int CNT_W = 8;
   localparam int TO    = 16;
   localparam int MR    = 2;
   localparam int NMAX  = 128;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             go = 1'b0;
   logic             abort = 1'b0;
   logic             done = 1'b0;
   logic [CNT_W-1:0] job_count = '0;
   logic             start, busy, complete, error;
   logic [CNT_W-1:0] jobs_done;
`ifdef JOB_SEQUENCER_STRAY_CNT_EN
   logic [7:0]       stray_count;
`endif

   always #5 clk = ~clk;

   job_sequencer #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TO),
      .MAX_RETRY      (MR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .job_count (job_count),
      .abort     (abort),
      .start     (start),
      .done      (done),
      .busy      (busy),
      .complete  (complete),
      .error     (error),
      .jobs_done (jobs_done)
`ifdef JOB_SEQUENCER_STRAY_CNT_EN
      ,
      .stray_count (stray_count)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   bit exp_start    [NMAX];
   bit exp_complete [NMAX];
   bit exp_busy     [NMAX];
   bit exp_error    [NMAX];
   int exp_jobs     [NMAX];
   bit go_drv       [NMAX];
   bit done_drv     [NMAX];
   bit abort_drv    [NMAX];
   int resp         [16];
   int cur = 0;
   bit chk_en = 1'b0;
   int run_len = 0;
   int prev_jobs = 0;
   bit prev_err = 1'b0;
   int sc_go = 0;
   int sc_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Per-cycle comparison against the model's expected trace.
   always @(negedge clk) begin
      if (chk_en) begin
         check($sformatf("c%0d start", cur), 32'(start), 32'(exp_start[cur]));
         check($sformatf("c%0d complete", cur), 32'(complete), 32'(exp_complete[cur]));
         check($sformatf("c%0d busy", cur), 32'(busy), 32'(exp_busy[cur]));
         check($sformatf("c%0d error", cur), 32'(error), 32'(exp_error[cur]));
         check($sformatf("c%0d jobs_done", cur), 32'(jobs_done), 32'(exp_jobs[cur]));
      end
   end

   // Job-level model: resp[] holds, per issued start, the cycles until the worker
   // answers (0 or >= TO means silent). Go is driven at cycle g.
   task automatic build(input int g, input int count, input int abort_c,
                        input int xgo_c, input int xdone_c);
      int t, att, jd, tries, endc, lv;
      bit ok, failed;
      for (int k = 0; k < NMAX; k++) begin
         exp_start[k] = 0; exp_complete[k] = 0; exp_busy[k] = 0;
         go_drv[k] = 0; done_drv[k] = 0; abort_drv[k] = 0;
         exp_error[k] = (k > g) ? 1'b0 : prev_err;
         exp_jobs[k]  = (k > g) ? 0 : prev_jobs;
      end
      go_drv[g] = 1;
      jd = 0; att = 0; endc = 0; failed = 0;
      if (count == 0) begin
         exp_complete[g+1] = 1;
         endc = g + 2;
      end else begin
         t = g + 1;
         for (int j = 0; j < count && !failed; j++) begin
            tries = 0; ok = 0;
            while (!ok && !failed) begin
               exp_start[t] = 1;
               lv = resp[att];
               att++;
               if (lv > 0 && lv <= TO - 1) begin
                  done_drv[t+lv] = 1;
                  jd++;
                  for (int k = t + lv + 1; k < NMAX; k++) exp_jobs[k] = jd;
                  t = t + lv + 1;
                  ok = 1;
               end else if (tries < MR) begin
                  tries++;
                  t = t + TO;
               end else begin
                  failed = 1;
                  for (int k = t + TO; k < NMAX; k++) exp_error[k] = 1;
                  endc = t + TO;
               end
            end
         end
         if (!failed) begin
            exp_complete[t] = 1;
            endc = t + 1;
         end
      end
      if (abort_c >= 0) begin
         abort_drv[abort_c] = 1;
         if (abort_c > g && abort_c < endc) begin
            for (int k = abort_c + 1; k < NMAX; k++) begin
               exp_start[k] = 0;
               exp_complete[k] = 0;
               done_drv[k] = 0;
               exp_jobs[k] = exp_jobs[abort_c];
               exp_error[k] = exp_error[abort_c];
            end
            endc = abort_c + 1;
         end
      end
      for (int k = 0; k < NMAX; k++) exp_busy[k] = (k > g) && (k < endc);
      if (xgo_c >= 0) go_drv[xgo_c] = 1;
      if (xdone_c >= 0) done_drv[xdone_c] = 1;
      run_len = endc + 3;
      prev_err = exp_error[run_len-1];
      prev_jobs = exp_jobs[run_len-1];
      sc_go = g;
      sc_count = count;
   endtask

   task automatic run();
      for (int c = 0; c < run_len; c++) begin
         cur = c;
         go = go_drv[c];
         done = done_drv[c];
         abort = abort_drv[c];
         job_count = (c == sc_go) ? CNT_W'(sc_count) : 8'hA5;
         chk_en = 1'b1;
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
      go = 0; done = 0; abort = 0;
   endtask

   function automatic int count_bits(input int which);
      int n = 0;
      for (int k = 0; k < NMAX; k++) begin
         if (which == 0 && exp_start[k]) n++;
         if (which == 1 && exp_complete[k]) n++;
         if (which == 2 && exp_busy[k]) n++;
      end
      return n;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("reset start", 32'(start), 0);
      check("reset busy", 32'(busy), 0);
      check("reset complete", 32'(complete), 0);
      check("reset error", 32'(error), 0);
      check("reset jobs_done", 32'(jobs_done), 0);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // Three jobs, done 2 cycles after each start, stray go and done mid-batch.
      resp[0] = 2; resp[1] = 2; resp[2] = 2;
      build(0, 3, -1, 5, 4);
      check("pin s1 start1", 32'(exp_start[1]), 1);
      check("pin s1 start4", 32'(exp_start[4]), 1);
      check("pin s1 start7", 32'(exp_start[7]), 1);
      check("pin s1 nstart", count_bits(0), 3);
      check("pin s1 complete10", 32'(exp_complete[10]), 1);
      check("pin s1 jobs", exp_jobs[11], 3);
      run();

      // Empty batch; abort in IDLE afterwards is ignored.
      build(0, 0, 3, -1, -1);
      check("pin s2 complete1", 32'(exp_complete[1]), 1);
      check("pin s2 busy cycles", count_bits(2), 1);
      check("pin s2 nstart", count_bits(0), 0);
      run();

      // Worker silent on job 2: two retries then error.
      resp[0] = 2; resp[1] = 0; resp[2] = 0; resp[3] = 0;
      build(0, 2, -1, -1, -1);
      check("pin s3 start4", 32'(exp_start[4]), 1);
      check("pin s3 start20", 32'(exp_start[20]), 1);
      check("pin s3 start36", 32'(exp_start[36]), 1);
      check("pin s3 err51", 32'(exp_error[51]), 0);
      check("pin s3 err52", 32'(exp_error[52]), 1);
      check("pin s3 jobs", exp_jobs[54], 1);
      check("pin s3 ncomplete", count_bits(1), 0);
      run();

      // Done on the expiry cycle wins over the timeout.
      resp[0] = TO - 1;
      build(0, 1, -1, -1, -1);
      check("pin s4 complete17", 32'(exp_complete[17]), 1);
      check("pin s4 nstart", count_bits(0), 1);
      run();

      // Abort in WAIT of job 3.
      resp[0] = 2; resp[1] = 2; resp[2] = 2; resp[3] = 2;
      build(0, 4, 8, -1, -1);
      check("pin s5 jobs9", exp_jobs[9], 2);
      check("pin s5 busy9", 32'(exp_busy[9]), 0);
      check("pin s5 nstart", count_bits(0), 3);
      run();

      // Restart after abort clears jobs_done.
      resp[0] = 3; resp[1] = 1;
      build(0, 2, -1, -1, -1);
      check("pin s6 jobs1", exp_jobs[1], 0);
      check("pin s6 complete7", 32'(exp_complete[7]), 1);
      run();

      // One retry that then succeeds.
      resp[0] = 2; resp[1] = 0; resp[2] = 4; resp[3] = 1; resp[4] = 1;
      build(0, 4, -1, -1, -1);
      run();

      // Abort in DONE keeps the complete pulse of that cycle.
      resp[0] = 1;
      build(0, 1, 3, -1, -1);
      check("pin s8 complete3", 32'(exp_complete[3]), 1);
      run();

      // Abort together with done in WAIT: done not counted.
      resp[0] = 2; resp[1] = 2;
      build(0, 2, 3, -1, -1);
      check("pin s9 jobs", exp_jobs[6], 0);
      run();

      // Abort in ISSUE of job 2.
      resp[0] = 2; resp[1] = 2;
      build(0, 2, 4, -1, -1);
      run();

      // Asynchronous reset mid-WAIT with done arriving during reset.
      go = 1; job_count = 8'd3;
      @(posedge clk); #1;
      go = 0; job_count = 8'hA5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst pre busy", 32'(busy), 1);
      reset = 1; done = 1;
      #1;
      check("rst async busy", 32'(busy), 0);
      check("rst async start", 32'(start), 0);
      check("rst async jobs", 32'(jobs_done), 0);
      @(posedge clk); #1;
      done = 0;
      #2 reset = 0;
      check("rst after busy", 32'(busy), 0);
      check("rst after complete", 32'(complete), 0);
      check("rst after error", 32'(error), 0);
`ifdef JOB_SEQUENCER_STRAY_CNT_EN
      check("rst stray", 32'(stray_count), 0);
`endif
      @(posedge clk); #1;
      done = 1;
      @(posedge clk); #1;
      done = 0;
      check("idle done busy", 32'(busy), 0);
      check("idle done start", 32'(start), 0);
      check("idle done jobs", 32'(jobs_done), 0);
`ifdef JOB_SEQUENCER_STRAY_CNT_EN
      check("idle stray", 32'(stray_count), 1);
`endif
      @(posedge clk); #1;
      check("idle later start", 32'(start), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
